// File: rtl/key_debounce_pkg.sv
// Shared definitions for the KEY[1:0] debouncer.
//   db_state_e  : per-channel debounce FSM state encoding
//   CNT_MAX_DEF : default stable-sample count (20 ms at 50 MHz)
//   clog2       : elaboration-time ceil(log2(v)), used to size the counter
package key_debounce_pkg;

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      WAIT_PRESS   = 2'd1,
      PRESSED      = 2'd2,
      WAIT_RELEASE = 2'd3
   } db_state_e;

   localparam int CNT_MAX_DEF = 1000000;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

endpackage

// File: rtl/debounce_chan.sv
// One debounce channel: input synchroniser, debounce FSM and stability counter,
// and registered level / press / release outputs.
//   clk, rst_n : clock, asynchronous active-low reset
//   key_raw    : raw asynchronous key bit
//   level      : debounced level, 1 = pressed
//   press      : one-cycle pulse on an accepted press
//   rls        : one-cycle pulse on an accepted release
//                ("release" is a reserved word, hence the short name)
module debounce_chan
   import key_debounce_pkg::*;
#(
   parameter int CNT_MAX     = CNT_MAX_DEF,
   parameter int SYNC_STAGES = 2,
   parameter int ACTIVE_LOW  = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_raw,
   output logic level,
   output logic press,
   output logic rls
);

   localparam int             CW       = clog2(CNT_MAX);
   localparam logic [CW-1:0]  CNT_LAST = CW'(CNT_MAX - 1);
   // Raw level of a key that is not pressed.
   localparam logic           IDLE     = (ACTIVE_LOW != 0);

   logic [SYNC_STAGES-1:0] sync_pipe;
   logic                   s;
   db_state_e              state, state_nxt;
   logic [CW-1:0]          cnt, cnt_nxt;
   logic                   level_nxt, press_nxt, rls_nxt;

   // Synchroniser resets to the idle raw level so reset never looks like a press.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) sync_pipe <= {SYNC_STAGES{IDLE}};
      else        sync_pipe <= {sync_pipe[SYNC_STAGES-2:0], key_raw};
   end

   // Polarity normalised after the last stage: s = 1 means pressed.
   assign s = sync_pipe[SYNC_STAGES-1] ^ IDLE;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         RELEASED: begin
            if (s) begin
               state_nxt = WAIT_PRESS;
               cnt_nxt   = '0;
            end
         end
         WAIT_PRESS: begin
            if (!s) begin
               state_nxt = RELEASED;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = PRESSED;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         PRESSED: begin
            if (!s) begin
               state_nxt = WAIT_RELEASE;
               cnt_nxt   = '0;
            end
         end
         WAIT_RELEASE: begin
            if (s) begin
               state_nxt = PRESSED;
               cnt_nxt   = '0;
            end else if (cnt == CNT_LAST) begin
               state_nxt = RELEASED;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = RELEASED;
            cnt_nxt   = '0;
         end
      endcase
   end

   // Outputs are decoded from the next state and registered alongside it, so
   // level and pulse change on the same edge as the state.
   assign level_nxt = (state_nxt == PRESSED) || (state_nxt == WAIT_RELEASE);
   assign press_nxt = (state == WAIT_PRESS)   && (state_nxt == PRESSED);
   assign rls_nxt   = (state == WAIT_RELEASE) && (state_nxt == RELEASED);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RELEASED;
         cnt   <= '0;
         level <= 1'b0;
         press <= 1'b0;
         rls   <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         level <= level_nxt;
         press <= press_nxt;
         rls   <= rls_nxt;
      end
   end

endmodule

// File: rtl/key_debounce2.sv
// Two-channel debouncer for the DE2 push-buttons, feeding and_gate's a/b.
//   clk, rst_n : 50 MHz board clock, asynchronous active-low reset
//   key_in[1:0]: raw keys; bit0 -> channel a, bit1 -> channel b
//   a, b       : debounced levels, 1 = pressed
//   press[1:0] : per-channel one-cycle pulse on accepted press
//   rls[1:0]   : per-channel one-cycle pulse on accepted release
//                ("release" is a reserved word, hence the short name)
module key_debounce2
   import key_debounce_pkg::*;
#(
   parameter int CNT_MAX        = CNT_MAX_DEF,
   parameter int SYNC_STAGES    = 2,
   parameter int KEY_ACTIVE_LOW = 1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] key_in,
   output logic       a,
   output logic       b,
   output logic [1:0] press,
   output logic [1:0] rls
);

   localparam int NUM_LANES = 2;

   logic [NUM_LANES-1:0] level;

   // Channels are fully independent; they share only clk and rst_n.
   for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_chan
      debounce_chan #(
         .CNT_MAX     (CNT_MAX),
         .SYNC_STAGES (SYNC_STAGES),
         .ACTIVE_LOW  (KEY_ACTIVE_LOW)
      ) u_chan (
         .clk     (clk),
         .rst_n   (rst_n),
         .key_raw (key_in[gi]),
         .level   (level[gi]),
         .press   (press[gi]),
         .rls     (rls[gi])
      );
   end

   assign a = level[0];
   assign b = level[1];

endmodule

// File: tb/tb_key_debounce2.sv
// Directed bench for key_debounce2 with CNT_MAX=4, SYNC_STAGES=2, 20 ns clock.
// Outputs are observed as {a, b, press[1:0], rls[1:0]} one time unit after
// the rising edge; inputs change at the same point, well before the next edge.
module tb_key_debounce2;

   logic       clk;
   logic       rst_n;
   logic [1:0] key_in;
   logic       a, b;
   logic [1:0] press, rls;

   int checks   = 0;
   int failures = 0;

   key_debounce2 #(
      .CNT_MAX        (4),
      .SYNC_STAGES    (2),
      .KEY_ACTIVE_LOW (1)
   ) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_in (key_in),
      .a      (a),
      .b      (b),
      .press  (press),
      .rls    (rls)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [5:0] exp);
      logic [5:0] obs;
      obs = {a, b, press, rls};
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed={a,b,press,rls}=%b expected=%b", tag, obs, exp);
      end
   endtask

   initial begin
      // Reset state, keys idle (high).
      rst_n  = 1'b0;
      key_in = 2'b11;
      #5;
      chk("reset_state", 6'b00_00_00);
      tick(2);
      chk("reset_held", 6'b00_00_00);
      rst_n = 1'b1;
      tick(4);
      chk("idle_after_reset", 6'b00_00_00);

      // Clean press on channel a: change settles before edge 1, accepted on edge 7.
      key_in = 2'b10;
      tick(6);
      chk("press_a_edge6", 6'b00_00_00);
      tick(1);
      chk("press_a_edge7", 6'b10_01_00);
      tick(1);
      chk("press_a_edge8", 6'b10_00_00);

      // Release of channel a.
      key_in = 2'b11;
      tick(6);
      chk("release_a_edge6", 6'b10_00_00);
      tick(1);
      chk("release_a_edge7", 6'b00_00_01);
      tick(1);
      chk("release_a_edge8", 6'b00_00_00);
      tick(3);

      // Bounce: low 3, high 1, low 2, then high -- never reaches 4 stable samples.
      key_in = 2'b10;
      tick(3);
      key_in = 2'b11;
      tick(1);
      key_in = 2'b10;
      tick(2);
      key_in = 2'b11;
      for (int i = 0; i < 10; i++) begin
         tick(1);
         chk("bounce_quiet", 6'b00_00_00);
      end
      // Then hold low: accepted exactly 7 edges after the final settle.
      key_in = 2'b10;
      tick(6);
      chk("bounce_hold_edge6", 6'b00_00_00);
      tick(1);
      chk("bounce_hold_edge7", 6'b10_01_00);
      key_in = 2'b11;
      tick(8);
      chk("bounce_released", 6'b00_00_00);
      tick(2);

      // Simultaneous press on both channels.
      key_in = 2'b00;
      tick(6);
      chk("simul_edge6", 6'b00_00_00);
      tick(1);
      chk("simul_edge7", 6'b11_11_00);
      checks++;
      assert ((a & b) === 1'b1) else begin
         failures++;
         $error("FAIL and_gate_f observed=%b expected=1", a & b);
      end
      tick(1);
      chk("simul_edge8", 6'b11_00_00);

      // Asynchronous reset asserted mid-cycle: outputs clear with no clock edge.
      #5;
      rst_n = 1'b0;
      #1;
      chk("async_reset", 6'b00_00_00);
      #3;
      rst_n = 1'b1;

      // Key still held low after reset: full latency again; reset at edge 5 mid-count.
      tick(4);
      chk("midcount_edge4", 6'b00_00_00);
      tick(1);
      rst_n = 1'b0;
      #1;
      chk("midcount_reset", 6'b00_00_00);
      #1;
      rst_n = 1'b1;
      tick(6);
      chk("after_reset_edge6", 6'b00_00_00);
      tick(1);
      chk("after_reset_edge7", 6'b11_11_00);
      tick(1);
      chk("after_reset_edge8", 6'b11_00_00);

      // Release both together.
      key_in = 2'b11;
      tick(7);
      chk("simul_release_edge7", 6'b00_00_11);
      tick(1);
      chk("simul_release_edge8", 6'b00_00_00);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
